// File: rtl/output_selector.sv
// ---------------------------------------------------------------------------
// output_selector
// Final output stage of the AES core. It selects either the decrypt result (PT)
// or the encrypt result (CT) and registers the choice onto the Result bus. Ry
// pulses high for every cycle that follows a capture.
//
// Ports
//   Clk    : system clock, rising-edge active
//   Rst    : asynchronous reset, active low
//   Sel    : source select (0 = PT / decrypt, 1 = CT / encrypt)
//   PT, CT : WIDTH-bit data from the inverse-cipher and cipher datapaths
//   En     : capture strobe, sampled on the rising edge of Clk
//   Result : registered selected data
//   Ry     : high when Result was updated on the last edge
//
// Build option
//   OUTSEL_ZEROIZE_EN : when defined, Result reads zero whenever Ry is low, so
//                       captured data is not left on the bus. The register
//                       contents are unaffected; only the output is gated.
// ---------------------------------------------------------------------------
module output_selector #(
  parameter int WIDTH = 128
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Sel,
  input  logic [WIDTH-1:0] PT,
  input  logic [WIDTH-1:0] CT,
  input  logic             En,
  output logic [WIDTH-1:0] Result,
  output logic             Ry
);

  logic [WIDTH-1:0] result_q, result_d;
  logic             sel_q, sel_d;
  logic             ry_q, ry_d;

  // The source of the last capture is recorded for observation only.
  logic unused_sel;
  assign unused_sel = sel_q;

  // The select is written as an if/else so that a Sel value that is not a
  // clean 1 (for example X or Z in simulation) falls through to PT.
  always_comb begin
    result_d = result_q;
    sel_d    = sel_q;
    ry_d     = 1'b0;
    if (En) begin
      ry_d = 1'b1;
      if (Sel == 1'b1) begin
        result_d = CT;
        sel_d    = 1'b1;
      end else begin
        result_d = PT;
        sel_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      result_q <= '0;
      sel_q    <= 1'b0;
      ry_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      sel_q    <= sel_d;
      ry_q     <= ry_d;
    end
  end

`ifdef OUTSEL_ZEROIZE_EN
  assign Result = ry_q ? result_q : '0;
`else
  assign Result = result_q;
`endif
  assign Ry = ry_q;

endmodule

// File: tb/tb_output_selector.sv
// ---------------------------------------------------------------------------
// tb_output_selector
// Scoreboard bench for output_selector. Each drive pushes the expected
// Result/Ry into a queue. The entry is popped and compared 1 ns after the
// capturing edge.
// ---------------------------------------------------------------------------
module tb_output_selector;

  localparam int WIDTH = 128;

  typedef struct packed {
    logic             ry;
    logic [WIDTH-1:0] res;
  } exp_t;

  logic             Clk;
  logic             Rst;
  logic             Sel;
  logic [WIDTH-1:0] PT;
  logic [WIDTH-1:0] CT;
  logic             En;
  logic [WIDTH-1:0] Result;
  logic             Ry;

  output_selector #(.WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Sel   (Sel),
    .PT    (PT),
    .CT    (CT),
    .En    (En),
    .Result(Result),
    .Ry    (Ry)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  // Reference model state
  logic [WIDTH-1:0] m_res = '0;
  logic             m_ry  = 1'b0;

  localparam logic [WIDTH-1:0] KPT = 128'h03c18e199ba5296289328eca914a59aa;
  localparam logic [WIDTH-1:0] KCT = 128'h5b448dd8c1beb2c7653f07f878c2c8e0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] vis();
`ifdef OUTSEL_ZEROIZE_EN
    return m_ry ? m_res : '0;
`else
    return m_res;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_res"}, Result, e.res);
      chk({tag, "_ry"}, {{(WIDTH-1){1'b0}}, Ry}, {{(WIDTH-1){1'b0}}, e.ry});
    end
  endtask

  // Apply one cycle of stimulus, then check the result after the edge.
  task automatic drive(input logic en, input logic sel, input logic [WIDTH-1:0] pt,
                       input logic [WIDTH-1:0] ct, input string tag);
    exp_t e;
    @(negedge Clk);
    En = en; Sel = sel; PT = pt; CT = ct;
    if (en === 1'b1) begin
      m_ry  = 1'b1;
      m_res = (sel === 1'b1) ? ct : pt;
    end else begin
      m_ry = 1'b0;
    end
    e.ry = m_ry; e.res = vis();
    sb.push_back(e);
    @(posedge Clk);
    #1;
    compare(tag);
  endtask

  // While reset is asserted, both outputs must read zero.
  task automatic rst_check(input string tag);
    exp_t e;
    m_res = '0; m_ry = 1'b0;
    e.ry = 1'b0; e.res = '0;
    sb.push_back(e);
    compare(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // T1: hold reset low while En is high and the data is random.
    Rst = 1'b0; En = 1'b1; Sel = 1'b1; PT = rnd128(); CT = rnd128();
    #2;
    rst_check("t1_rst_t0");
    @(posedge Clk); #1;
    rst_check("t1_rst_edge");
    @(negedge Clk);
    En = 1'b0;
    Rst = 1'b1;

    // T2: decrypt path
    drive(1'b1, 1'b0, KPT, KCT, "t2_dec");
    drive(1'b0, 1'b0, KPT, KCT, "t2_after");

    // T3: encrypt path
    drive(1'b1, 1'b1, KPT, KCT, "t3_enc");

    // T4: inputs change while En is low; Result holds (or is zeroized).
    for (int i = 0; i < 5; i++)
      drive(1'b0, 1'($urandom_range(0, 1)), rnd128(), rnd128(), "t4_hold");

    // T5: three back-to-back captures with Sel going 0, 1, 0.
    drive(1'b1, 1'b0, KPT, KCT, "t5_s0");
    drive(1'b1, 1'b1, KPT, KCT, "t5_s1");
    drive(1'b1, 1'b0, KPT, KCT, "t5_s2");
    drive(1'b0, 1'b0, KPT, KCT, "t5_end");

    // Boundary cases: Sel = X selects PT, and data with extreme bit patterns.
    drive(1'b1, 1'bx, KPT, KCT, "selx");
    drive(1'b1, 1'b1, '0, '1, "ones");
    drive(1'b1, 1'b0, {1'b1, {(WIDTH-1){1'b0}}}, '1, "msb");

    // Random captures
    for (int i = 0; i < 8; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd128(), rnd128(), "rand");

    // T6: reset asserted between two captures while En stays high.
    drive(1'b1, 1'b1, KPT, KCT, "t6_pre");
    #2;
    Rst = 1'b0;
    #1;
    rst_check("t6_async");
    @(posedge Clk); #1;
    rst_check("t6_held");
    @(negedge Clk);
    Rst = 1'b1;
    drive(1'b1, 1'b0, KPT, KCT, "t6_post_pt");
    drive(1'b1, 1'b1, KPT, KCT, "t6_post_ct");
    drive(1'b0, 1'b0, '0, '0, "t6_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
